keylock_ctrl: RTL

- Sequencing controller for the digit-code lock.
- Takes strobed digits from the keypad front-end and buffers a full CODE_LEN-digit attempt. Compares it against a programmable code register, then drives the lock output.
- Adds failed-attempt counting, timed lockout, auto-relock and in-field code reprogramming.
- Sits between the keypad decoder and the lock actuator/status logic.

---
 rtl/keylock_pkg.sv | 44 ++++
 rtl/keylock_if.sv | 24 ++
 rtl/keylock_timer.sv | 25 ++
 rtl/keylock_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/keylock_pkg.sv
// Shared types, constants and digit helpers for the digit-code lock controller.
package keylock_pkg;

  localparam int unsigned DIGIT_W  = 3;
  localparam int unsigned CODE_LEN = 6;
  localparam int unsigned CODE_W   = DIGIT_W * CODE_LEN;
  localparam int unsigned MAX_FAIL = 3;
  localparam int unsigned FAIL_W   = $clog2(MAX_FAIL + 1);
  localparam int unsigned IDX_W    = $clog2(CODE_LEN + 1);

  // First digit lives in the MSBs: 3,3,5,2,5,6.
  localparam logic [CODE_W-1:0] DEFAULT_CODE = 18'o335256;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROG    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  // Digit idx of a code vector, digit 0 in the MSBs.
  function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                    input logic [IDX_W-1:0]  idx);
    logic [DIGIT_W-1:0] d;
    d = '0;
    for (int i = 0; i < int'(CODE_LEN); i++)
      if (idx == IDX_W'(i)) d = code[CODE_W-1-i*DIGIT_W -: DIGIT_W];
    return d;
  endfunction

  // Return code with digit idx replaced by val.
  function automatic logic [CODE_W-1:0] set_digit(input logic [CODE_W-1:0]  code,
                                                  input logic [IDX_W-1:0]   idx,
                                                  input logic [DIGIT_W-1:0] val);
    logic [CODE_W-1:0] c;
    c = code;
    for (int i = 0; i < int'(CODE_LEN); i++)
      if (idx == IDX_W'(i)) c[CODE_W-1-i*DIGIT_W -: DIGIT_W] = val;
    return c;
  endfunction

endpackage

// File: rtl/keylock_if.sv
// Keypad-side inputs and lock/status outputs of the controller, bundled.
interface keylock_if;
  import keylock_pkg::*;

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               prog_en;
  logic               relock;
  logic               locked;
  logic               alarm;
  logic               unlock_pulse;
  logic               fail_pulse;
  logic [FAIL_W-1:0]  fail_count;

  modport master (
    output digit_valid, digit, prog_en, relock,
    input  locked, alarm, unlock_pulse, fail_pulse, fail_count
  );

  modport slave (
    input  digit_valid, digit, prog_en, relock,
    output locked, alarm, unlock_pulse, fail_pulse, fail_count
  );
endinterface

// File: rtl/keylock_timer.sv
// Loadable down-counter shared by the entry-timeout, auto-relock and lockout phases.
module keylock_timer #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Load has priority; otherwise count down while enabled and stop at zero.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_count <= '0;
    else if (i_load)                 r_count <= i_load_val;
    else if (i_en && r_count != '0)  r_count <= r_count - 1'b1;
  end

  assign o_expired = i_en && (r_count == '0);

endmodule

// File: rtl/keylock_ctrl.sv
// Digit-code lock sequencer: collects an attempt, compares, opens, counts
// failures, locks out, auto-relocks and supports in-field code reprogramming.
module keylock_ctrl
  import keylock_pkg::*;
#(
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned ENTRY_TIMEOUT  = 200
) (
  input  logic clk,
  input  logic reset_n,
  keylock_if.slave bus
);

  localparam int unsigned T_MAX1  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned T_MAX   = (T_MAX1 > ENTRY_TIMEOUT) ? T_MAX1 : ENTRY_TIMEOUT;
  localparam int unsigned TIMER_W = $clog2(T_MAX) + 1;

  state_t              r_state,  w_state_nxt;
  logic [CODE_W-1:0]   r_code,   w_code_nxt;
  logic [CODE_W-1:0]   r_shadow, w_shadow_nxt;
  logic [IDX_W-1:0]    r_idx,    w_idx_nxt;
  logic                r_match,  w_match_nxt;
  logic [FAIL_W-1:0]   r_fail,   w_fail_nxt;
  logic                r_unlock_pulse, w_unlock_nxt;
  logic                r_fail_pulse,   w_fail_pulse_nxt;

  logic                w_t_load, w_t_en, w_t_expired;
  logic [TIMER_W-1:0]  w_t_load_val;
  logic                w_last_digit, w_digit_eq;
  logic [FAIL_W-1:0]   w_fail_inc;

  keylock_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_t_load),
    .i_load_val (w_t_load_val),
    .i_en       (w_t_en),
    .o_expired  (w_t_expired)
  );

  // Timer runs only in the timed states; PROG holds it paused.
  assign w_t_en       = (r_state == ST_ENTRY) || (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);
  assign w_last_digit = (r_idx == IDX_W'(CODE_LEN - 1));
  assign w_digit_eq   = (bus.digit == code_digit(r_code, r_idx));
  assign w_fail_inc   = r_fail + 1'b1;

  // Next-state and next-register decode for the whole controller.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_code_nxt       = r_code;
    w_shadow_nxt     = r_shadow;
    w_idx_nxt        = r_idx;
    w_match_nxt      = r_match;
    w_fail_nxt       = r_fail;
    w_unlock_nxt     = 1'b0;
    w_fail_pulse_nxt = 1'b0;
    w_t_load         = 1'b0;
    w_t_load_val     = '0;

    unique case (r_state)
      ST_LOCKED: begin
        if (bus.digit_valid) begin
          w_match_nxt  = w_digit_eq;   // r_idx is 0 here
          w_idx_nxt    = IDX_W'(1);
          w_state_nxt  = ST_ENTRY;
          w_t_load     = 1'b1;
          w_t_load_val = TIMER_W'(ENTRY_TIMEOUT);
        end
      end
      ST_ENTRY: begin
        // A mismatch only clears the flag; the full attempt is always collected.
        if (bus.digit_valid) begin
          w_match_nxt  = r_match && w_digit_eq;
          w_idx_nxt    = r_idx + 1'b1;
          w_t_load     = 1'b1;
          w_t_load_val = TIMER_W'(ENTRY_TIMEOUT);
          if (w_last_digit) w_state_nxt = ST_CHECK;
        end else if (w_t_expired) begin
          w_state_nxt = ST_LOCKED;
          w_idx_nxt   = '0;
          w_match_nxt = 1'b1;
        end
      end
      ST_CHECK: begin
        w_idx_nxt   = '0;
        w_match_nxt = 1'b1;
        if (r_match) begin
          w_state_nxt  = ST_OPEN;
          w_fail_nxt   = '0;
          w_unlock_nxt = 1'b1;
          w_t_load     = 1'b1;
          w_t_load_val = TIMER_W'(UNLOCK_CYCLES);
        end else begin
          w_fail_nxt       = w_fail_inc;
          w_fail_pulse_nxt = 1'b1;
          if (w_fail_inc == FAIL_W'(MAX_FAIL)) begin
            w_state_nxt  = ST_LOCKOUT;
            w_t_load     = 1'b1;
            w_t_load_val = TIMER_W'(LOCKOUT_CYCLES);
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_OPEN: begin
        if (bus.relock || w_t_expired) begin
          w_state_nxt = ST_LOCKED;
        end else if (bus.prog_en) begin
          w_state_nxt = ST_PROG;
          w_idx_nxt   = '0;
        end
      end
      ST_PROG: begin
        if (bus.relock) begin
          w_state_nxt = ST_LOCKED;
          w_idx_nxt   = '0;
        end else if (!bus.prog_en) begin
          w_state_nxt  = ST_OPEN;
          w_idx_nxt    = '0;
          w_t_load     = 1'b1;
          w_t_load_val = TIMER_W'(UNLOCK_CYCLES);
        end else if (bus.digit_valid) begin
          w_shadow_nxt = set_digit(r_shadow, r_idx, bus.digit);
          w_idx_nxt    = r_idx + 1'b1;
          if (w_last_digit) begin
            // Commit the complete new code in one edge.
            w_code_nxt   = set_digit(r_shadow, r_idx, bus.digit);
            w_state_nxt  = ST_OPEN;
            w_idx_nxt    = '0;
            w_t_load     = 1'b1;
            w_t_load_val = TIMER_W'(UNLOCK_CYCLES);
          end
        end
      end
      ST_LOCKOUT: begin
        if (w_t_expired) begin
          w_fail_nxt  = '0;
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_idx_nxt   = '0;
        w_match_nxt = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  // NOTE: the code register resets to the factory code; the shadow is reset
  // too, but its contents never matter until all digits are rewritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_LOCKED;
      r_code         <= DEFAULT_CODE;
      r_shadow       <= '0;
      r_idx          <= '0;
      r_match        <= 1'b1;
      r_fail         <= '0;
      r_unlock_pulse <= 1'b0;
      r_fail_pulse   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_code         <= w_code_nxt;
      r_shadow       <= w_shadow_nxt;
      r_idx          <= w_idx_nxt;
      r_match        <= w_match_nxt;
      r_fail         <= w_fail_nxt;
      r_unlock_pulse <= w_unlock_nxt;
      r_fail_pulse   <= w_fail_pulse_nxt;
    end
  end

  assign bus.locked       = !((r_state == ST_OPEN) || (r_state == ST_PROG));
  assign bus.alarm        = (r_state == ST_LOCKOUT);
  assign bus.unlock_pulse = r_unlock_pulse;
  assign bus.fail_pulse   = r_fail_pulse;
  assign bus.fail_count   = r_fail;

endmodule
